// File: rtl/fetch_buffer_pkg.sv
// Shared CPU constants for the instruction fetch path.
// This package holds the data and address widths, the word step and the default reset PC.
package fetch_buffer_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Clear the byte offset so the result is a word address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~(PC_INC - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO that stores {pc, inst} pairs between the ROM and decode.
// Flush takes priority over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !flush_i && !full_o;
    assign do_pop  = pop_i && !flush_i && !empty_o;
    assign rdata_o = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch unit: the fetch PC walks the ROM one word per cycle into a queue for decode.
// A redirect flushes the queue and restarts fetching at the aligned target.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] io_romRead_addr,
    output logic              io_romRead_ce,
    input  logic [INST_W-1:0] io_romRead_data,
    output logic              io_inst_valid,
    input  logic              io_inst_ready,
    output logic [ADDR_W-1:0] io_inst_pc,
    output logic [INST_W-1:0] io_inst_data,
    input  logic              io_redirect_valid,
    input  logic [ADDR_W-1:0] io_redirect_target
);

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     fifo_full, fifo_empty, fifo_pop;
    logic [ADDR_W+INST_W-1:0] fifo_rdata;

    // Ready only feeds the pop strobe, so nothing visible depends on it combinationally.
    assign io_romRead_ce   = reset && !fifo_full && !io_redirect_valid;
    assign io_romRead_addr = pc_q;
    assign io_inst_valid   = reset && !fifo_empty && !io_redirect_valid;
    assign fifo_pop        = io_inst_valid && io_inst_ready;
    assign {io_inst_pc, io_inst_data} = fifo_rdata;

    always_comb begin
        pc_d = pc_q;
        if (io_redirect_valid)  pc_d = word_align(io_redirect_target);
        else if (io_romRead_ce) pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (io_redirect_valid),
        .push_i  (io_romRead_ce),
        .pop_i   (fifo_pop),
        .wdata_i ({pc_q, io_romRead_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a reference queue and fetch PC are kept alongside the DUT.
// The ROM returns addr ^ 32'hA5A5_0000.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic [31:0] io_romRead_addr;
    logic        io_romRead_ce;
    logic [31:0] io_romRead_data;
    logic        io_inst_valid;
    logic        io_inst_ready;
    logic [31:0] io_inst_pc;
    logic [31:0] io_inst_data;
    logic        io_redirect_valid;
    logic [31:0] io_redirect_target;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        sbq[$];
    logic [31:0] mpc;
    int          n_tests;
    int          n_fail;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_romRead_addr    (io_romRead_addr),
        .io_romRead_ce      (io_romRead_ce),
        .io_romRead_data    (io_romRead_data),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst_pc         (io_inst_pc),
        .io_inst_data       (io_inst_data),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_target (io_redirect_target)
    );

    assign io_romRead_data = io_romRead_addr ^ KEY;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check before the rising edge, then advance the model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        bit   exp_ce, exp_valid;
        ent_t e;
        @(negedge clock);
        io_inst_ready      = rdy;
        io_redirect_valid  = redir;
        io_redirect_target = tgt;
        #1;
        exp_ce    = (sbq.size() < DEPTH) && !redir;
        exp_valid = (sbq.size() != 0) && !redir;
        check_val("ce", 32'(io_romRead_ce), 32'(exp_ce));
        check_val("addr", io_romRead_addr, mpc);
        check_val("valid", 32'(io_inst_valid), 32'(exp_valid));
        if (redir) begin
            sbq.delete();
            mpc = tgt & ~32'h3;
        end else begin
            if (exp_valid) begin
                check_val("head_pc", io_inst_pc, sbq[0].pc);
                check_val("head_data", io_inst_data, sbq[0].data);
                if (rdy) begin
                    e = sbq.pop_front();
                    check_val("xfer_pc", io_inst_pc, e.pc);
                    check_val("xfer_data", io_inst_data, e.data);
                end
            end
            if (exp_ce) begin
                sbq.push_back('{mpc, mpc ^ KEY});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        reset              = 1'b0;
        io_inst_ready      = 1'b0;
        io_redirect_valid  = 1'b0;
        io_redirect_target = 32'h0;
        mpc                = RPC;

        // Held in reset across two clock edges.
        @(posedge clock);
        @(posedge clock);
        #2;
        check_val("rst_ce", 32'(io_romRead_ce), 32'd0);
        check_val("rst_valid", 32'(io_inst_valid), 32'd0);
        check_val("rst_addr", io_romRead_addr, RPC);
        reset = 1'b1;

        // Streaming with ready held high.
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // Back-pressure until the queue is full, then drain.
        step(1'b1, 1'b1, 32'h0);
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check_val("full_addr", io_romRead_addr, 32'h10);
        check_val("full_ce", 32'(io_romRead_ce), 32'd0);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // Redirect with three entries queued.
        step(1'b0, 1'b1, 32'h200);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0103);
        check_val("redir_valid", 32'(io_inst_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check_val("redir_addr", io_romRead_addr, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        check_val("redir_out_pc", io_inst_pc, 32'h100);
        check_val("redir_out_vld", 32'(io_inst_valid), 32'd1);

        // Redirect while full, with ready also high.
        step(1'b0, 1'b1, 32'h500);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        check_val("fullredir_vld", 32'(io_inst_valid), 32'd0);
        check_val("fullredir_addr", io_romRead_addr, 32'h40);

        // Address wrap past the top of memory.
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        check_val("wrap_pc", io_inst_pc, 32'h0);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // Random ready and occasional redirects.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), $urandom);
        end

        // Reset asserted between edges with two entries queued.
        step(1'b1, 1'b1, 32'h300);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_ce", 32'(io_romRead_ce), 32'd0);
        check_val("midrst_valid", 32'(io_inst_valid), 32'd0);
        check_val("midrst_addr", io_romRead_addr, RPC);
        sbq.delete();
        mpc = RPC;
        @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (6) step(1'b1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
